// File: rtl/multicycle_alu_if.sv
// multicycle_alu_if
// Request/response bundle between a requester and the multicycle ALU.
// Every signal takes its name from the ALU's point of view: _i is driven
// into the ALU and _o is driven by the ALU.
//
// Signals:
//   start_i          request strobe; accepted when ready_o is high
//   alu_operation_i  4-bit ALU control code
//   a_data_i         operand A
//   b_data_i         operand B, also the source of a shift
//   shamt_i          5-bit shift amount
//   ready_o          ALU can accept a request this cycle
//   done_o           one-cycle completion pulse
//   result_o         registered result
//   zero_o           registered flag, high when result_o is zero
//   illegal_o        registered flag, high when the code was not recognised
//
// Modports:
//   master  the requester side, which drives the _i signals
//   slave   the ALU side, which drives the _o signals
interface multicycle_alu_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  start_i;
  logic [3:0]            alu_operation_i;
  logic [DATA_WIDTH-1:0] a_data_i;
  logic [DATA_WIDTH-1:0] b_data_i;
  logic [4:0]            shamt_i;
  logic                  ready_o;
  logic                  done_o;
  logic [DATA_WIDTH-1:0] result_o;
  logic                  zero_o;
  logic                  illegal_o;

  modport master (
    output start_i, alu_operation_i, a_data_i, b_data_i, shamt_i,
    input  ready_o, done_o, result_o, zero_o, illegal_o
  );

  modport slave (
    input  start_i, alu_operation_i, a_data_i, b_data_i, shamt_i,
    output ready_o, done_o, result_o, zero_o, illegal_o
  );
endinterface

// File: rtl/multicycle_alu.sv
// multicycle_alu
// Sequential ALU for multi-cycle datapaths. It runs the 4-bit codes produced
// by the ALU control decoder. Operands and the code are latched on an accepted
// start. The result and flags come back registered, together with a
// one-cycle done pulse.
//
// The default build shifts iteratively, one bit per cycle, so a shift takes
// shamt+1 edges. Defining MULTICYCLE_ALU_BARREL_SHIFT_EN replaces this with a
// combinational barrel shifter. Shifts then take the single-edge EXEC path,
// and the SHIFT state and its counter are removed. Results are the same in
// both builds; only the latency changes.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-low reset
//   bus    multicycle_alu_if slave modport (see interface header)
//
// Parameters:
//   DATA_WIDTH  operand/result width (the shift amount is always 5 bits)
module multicycle_alu #(
  parameter int DATA_WIDTH = 32
) (
  input  logic            clk,
  input  logic            reset,
  multicycle_alu_if.slave bus
);

  localparam logic [3:0] OP_LUI = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_SLL = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0011;
  localparam logic [3:0] OP_SRL = 4'b0100;
  localparam logic [3:0] OP_SUB = 4'b0101;
  localparam logic [3:0] OP_AND = 4'b0110;
  localparam logic [3:0] OP_NOR = 4'b0111;

`ifdef MULTICYCLE_ALU_BARREL_SHIFT_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;
`endif

  state_t                state_q;
  logic [3:0]            opcode_q;
  logic [DATA_WIDTH-1:0] a_q;
  // In the iterative build b_q is also the working register of the shifter.
  logic [DATA_WIDTH-1:0] b_q;
`ifdef MULTICYCLE_ALU_BARREL_SHIFT_EN
  logic [4:0]            shamt_q;
`else
  logic [4:0]            count_q;
`endif
  logic [DATA_WIDTH-1:0] result_q;
  logic                  zero_q;
  logic                  illegal_q;
  logic                  done_q;

  logic [DATA_WIDTH-1:0] execResult_d;
  logic                  execIllegal_d;

`ifndef MULTICYCLE_ALU_BARREL_SHIFT_EN
  function automatic logic isShift(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL);
  endfunction
`endif

  // Single-edge datapath used by the EXEC state. Unrecognised codes give 0
  // and raise the illegal flag.
  always_comb begin
    execResult_d  = '0;
    execIllegal_d = 1'b0;
    case (opcode_q)
      OP_LUI: execResult_d = b_q << 16;
      OP_OR:  execResult_d = a_q | b_q;
      OP_ADD: execResult_d = a_q + b_q;
      OP_SUB: execResult_d = a_q - b_q;
      OP_AND: execResult_d = a_q & b_q;
      OP_NOR: execResult_d = ~(a_q | b_q);
`ifdef MULTICYCLE_ALU_BARREL_SHIFT_EN
      OP_SLL: execResult_d = b_q << shamt_q;
      OP_SRL: execResult_d = b_q >> shamt_q;
`else
      // Shifts never reach EXEC in this build; they finish in SHIFT.
      OP_SLL, OP_SRL: execResult_d = b_q;
`endif
      default: execIllegal_d = 1'b1;
    endcase
  end

  // Control FSM with registered outputs. DONE lasts exactly one cycle, so
  // done_q is raised only on the edge that enters DONE. A start seen in DONE
  // is accepted immediately, which gives back-to-back operation.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      opcode_q  <= '0;
      a_q       <= '0;
      b_q       <= '0;
`ifdef MULTICYCLE_ALU_BARREL_SHIFT_EN
      shamt_q   <= '0;
`else
      count_q   <= '0;
`endif
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (bus.start_i) begin
            opcode_q <= bus.alu_operation_i;
            a_q      <= bus.a_data_i;
            b_q      <= bus.b_data_i;
`ifdef MULTICYCLE_ALU_BARREL_SHIFT_EN
            shamt_q  <= bus.shamt_i;
            state_q  <= ST_EXEC;
`else
            count_q  <= bus.shamt_i;
            state_q  <= isShift(bus.alu_operation_i) ? ST_SHIFT : ST_EXEC;
`endif
          end else begin
            state_q <= ST_IDLE;
          end
        end

        ST_EXEC: begin
          result_q  <= execResult_d;
          zero_q    <= (execResult_d == '0);
          illegal_q <= execIllegal_d;
          done_q    <= 1'b1;
          state_q   <= ST_DONE;
        end

`ifndef MULTICYCLE_ALU_BARREL_SHIFT_EN
        // One bit per cycle. A zero count on entry completes on the next
        // edge with b_q unchanged, so shamt=0 returns B.
        ST_SHIFT: begin
          if (count_q != 5'd0) begin
            b_q     <= (opcode_q == OP_SLL) ? (b_q << 1) : (b_q >> 1);
            count_q <= count_q - 5'd1;
          end else begin
            result_q  <= b_q;
            zero_q    <= (b_q == '0);
            illegal_q <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= ST_DONE;
          end
        end
`endif

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // ready_o is a decode of the state register only.
  assign bus.ready_o   = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign bus.done_o    = done_q;
  assign bus.result_o  = result_q;
  assign bus.zero_o    = zero_q;
  assign bus.illegal_o = illegal_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// tb_multicycle_alu
// Directed and randomised bench for multicycle_alu. A reference model built
// from the operation table supplies the expected result, flags and latency.
// The bench follows the DUT's build: when MULTICYCLE_ALU_BARREL_SHIFT_EN is
// defined it expects a latency of one edge for every code.
module tb_multicycle_alu;

  localparam int DW      = 32;
  localparam int TIMEOUT = 64;

  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  multicycle_alu_if #(.DATA_WIDTH(DW)) bus ();

  multicycle_alu #(.DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock with a 10-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model, written straight from the operation table.
  function automatic logic [31:0] refResult(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [4:0] sh);
    longint unsigned wide;
    case (op)
      4'd0: return {b[15:0], 16'h0000};
      4'd1: return a | b;
      4'd2: begin
        wide = 64'(b) * (64'd1 << sh);
        return wide[31:0];
      end
      4'd3: return a + b;
      4'd4: return b / (32'd1 << sh);
      4'd5: return a - b;
      4'd6: return a & b;
      4'd7: return ~(a | b);
      default: return 32'h0;
    endcase
  endfunction

  function automatic int refLatency(input logic [3:0] op, input logic [4:0] sh);
`ifdef MULTICYCLE_ALU_BARREL_SHIFT_EN
    return 1;
`else
    return (op == 4'd2 || op == 4'd4) ? int'(sh) + 1 : 1;
`endif
  endfunction

  // One comparison: count it, and on a mismatch count the failure and report it.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request and let it be accepted on the next edge. Afterwards,
  // scramble the operand inputs, because the DUT must ignore them outside
  // the accept edge.
  task automatic applyStimulus(input string tag, input logic [3:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] sh);
    checkOutput({tag, "_ready"}, 32'(bus.ready_o), 32'd1);
    bus.start_i         = 1'b1;
    bus.alu_operation_i = op;
    bus.a_data_i        = a;
    bus.b_data_i        = b;
    bus.shamt_i         = sh;
    tick();
    bus.start_i         = 1'b0;
    bus.alu_operation_i = 4'($urandom);
    bus.a_data_i        = $urandom;
    bus.b_data_i        = $urandom;
    bus.shamt_i         = 5'($urandom);
    checkOutput({tag, "_noEarlyDone"}, 32'(bus.done_o), 32'd0);
  endtask

  // Count edges until done_o shows up. An expired budget returns TIMEOUT+1,
  // which makes the caller's latency check fail.
  task automatic waitDone(output int lat);
    lat = TIMEOUT + 1;
    for (int e = 1; e <= TIMEOUT; e++) begin
      tick();
      if (bus.done_o === 1'b1) begin
        lat = e;
        break;
      end
    end
  endtask

  task automatic runCase(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sh);
    logic [31:0] expRes;
    int          lat;
    expRes = refResult(op, a, b, sh);
    applyStimulus(tag, op, a, b, sh);
    waitDone(lat);
    checkOutput({tag, "_latency"}, 32'(lat), 32'(refLatency(op, sh)));
    checkOutput({tag, "_result"}, bus.result_o, expRes);
    checkOutput({tag, "_zero"}, 32'(bus.zero_o), 32'(expRes == 32'h0));
    checkOutput({tag, "_illegal"}, 32'(bus.illegal_o), 32'(op > 4'd7));
  endtask

  task automatic countDones(input int edges, output int n);
    n = 0;
    for (int e = 0; e < edges; e++) begin
      tick();
      if (bus.done_o === 1'b1) n++;
    end
  endtask

  initial begin
    int n;
    int lat;
    logic [3:0] rop;

    reset               = 1'b0;
    bus.start_i         = 1'b1;
    bus.alu_operation_i = 4'd3;
    bus.a_data_i        = 32'h1234_5678;
    bus.b_data_i        = 32'h1;
    bus.shamt_i         = 5'd3;

    // Reset held for two edges with start high.
    tick();
    tick();
    checkOutput("rst_ready", 32'(bus.ready_o), 32'd1);
    checkOutput("rst_done", 32'(bus.done_o), 32'd0);
    checkOutput("rst_result", bus.result_o, 32'd0);
    checkOutput("rst_zero", 32'(bus.zero_o), 32'd0);
    checkOutput("rst_illegal", 32'(bus.illegal_o), 32'd0);
    bus.start_i = 1'b0;
    reset       = 1'b1;
    tick();

    // Directed cases taken from the operation table.
    runCase("add_wrap", 4'd3, 32'hFFFF_FFFF, 32'h1, 5'd0);
    runCase("sub_neg", 4'd5, 32'd5, 32'd7, 5'd0);
    runCase("sll31", 4'd2, 32'h0, 32'h1, 5'd31);
    runCase("srl0", 4'd4, 32'h0, 32'h8000_0000, 5'd0);
    runCase("srl7", 4'd4, 32'h0, 32'hF000_00F0, 5'd7);
    runCase("nor0", 4'd7, 32'h0, 32'h0, 5'd0);
    runCase("lui", 4'd0, 32'hDEAD_BEEF, 32'h0000_1234, 5'd0);
    runCase("and", 4'd6, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd0);
    runCase("or", 4'd1, 32'hA000_0001, 32'h0500_0010, 5'd0);
    runCase("illegal9", 4'd9, 32'h1111_1111, 32'h2222_2222, 5'd4);
    runCase("illegalF", 4'd15, 32'h1, 32'h1, 5'd0);

`ifndef MULTICYCLE_ALU_BARREL_SHIFT_EN
    // A start pulse during a shift is ignored and only one done appears.
    applyStimulus("busy", 4'd2, 32'h0, 32'h3, 5'd10);
    tick();
    checkOutput("busy_notReady", 32'(bus.ready_o), 32'd0);
    bus.start_i         = 1'b1;
    bus.alu_operation_i = 4'd3;
    bus.a_data_i        = 32'h1;
    bus.b_data_i        = 32'h1;
    tick();
    bus.start_i = 1'b0;
    waitDone(lat);
    checkOutput("busy_latency", 32'(lat), 32'd9);
    checkOutput("busy_result", bus.result_o, 32'h0000_0C00);
    countDones(20, n);
    checkOutput("busy_singleDone", 32'(n), 32'd0);
`endif

    // Back-to-back: start stays high through DONE, so an ADD followed by an
    // OR gives done pulses two cycles apart.
    bus.start_i         = 1'b1;
    bus.alu_operation_i = 4'd3;
    bus.a_data_i        = 32'd100;
    bus.b_data_i        = 32'd23;
    tick();
    bus.alu_operation_i = 4'd1;
    bus.a_data_i        = 32'h00F0_0000;
    bus.b_data_i        = 32'h0000_000F;
    tick();
    checkOutput("b2b_done1", 32'(bus.done_o), 32'd1);
    checkOutput("b2b_result1", bus.result_o, 32'd123);
    tick();
    bus.start_i = 1'b0;
    checkOutput("b2b_gap", 32'(bus.done_o), 32'd0);
    tick();
    checkOutput("b2b_done2", 32'(bus.done_o), 32'd1);
    checkOutput("b2b_result2", bus.result_o, 32'h00F0_000F);
    tick();

    // Reset on edge 4 of a long shift discards it.
    applyStimulus("rstShift", 4'd2, 32'h0, 32'h5, 5'd20);
    tick();
    tick();
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    checkOutput("rstShift_ready", 32'(bus.ready_o), 32'd1);
    checkOutput("rstShift_done", 32'(bus.done_o), 32'd0);
    checkOutput("rstShift_result", bus.result_o, 32'd0);
    checkOutput("rstShift_zero", 32'(bus.zero_o), 32'd0);
    countDones(30, n);
    checkOutput("rstShift_noDone", 32'(n), 32'd0);
    runCase("postRst_add", 4'd3, 32'd40, 32'd2, 5'd0);

    // Random requests compared against the reference model.
    for (int i = 0; i < 40; i++) begin
      rop = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
      runCase($sformatf("rand%0d_op%0d", i, rop), rop, $urandom, $urandom, 5'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
